// File: rtl/vx_perf_cache_counters_if.sv
// Cache perf interface between a cache's counter unit and its consumer.
//   master (counter unit): drives the eight counters, the sticky overflow
//                          flags and the snap_valid pulse; reads snap_req.
//   slave  (consumer)    : drives snap_req; reads everything else.
// overflow bit order: 0 reads, 1 writes, 2 read_misses, 3 write_misses,
// 4 bank_stalls, 5 mshr_stalls, 6 mem_stalls, 7 crsp_stalls.
interface vx_perf_cache_counters_if #(
  parameter int CTR_BITS = 44
);
  logic [CTR_BITS-1:0] reads;
  logic [CTR_BITS-1:0] writes;
  logic [CTR_BITS-1:0] read_misses;
  logic [CTR_BITS-1:0] write_misses;
  logic [CTR_BITS-1:0] bank_stalls;
  logic [CTR_BITS-1:0] mshr_stalls;
  logic [CTR_BITS-1:0] mem_stalls;
  logic [CTR_BITS-1:0] crsp_stalls;
  logic [7:0]          overflow;
  logic                snap_req;
  logic                snap_valid;

  modport master (
    output reads, writes, read_misses, write_misses,
           bank_stalls, mshr_stalls, mem_stalls, crsp_stalls,
           overflow, snap_valid,
    input  snap_req
  );

  modport slave (
    input  reads, writes, read_misses, write_misses,
           bank_stalls, mshr_stalls, mem_stalls, crsp_stalls,
           overflow, snap_valid,
    output snap_req
  );
endinterface

// File: rtl/vx_perf_cache_counters.sv
// Cache performance-counter unit. Per-bank / per-port event strobes are
// gated by enable and registered (stage 1), then reduced by popcount and
// accumulated into eight counters (stage 2). Supports wrap or saturate
// arithmetic, sticky overflow flags, synchronous clear and an optional
// atomic snapshot into shadow registers.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enable            gates events sampled in the same cycle
//   clear             synchronous clear of counters, flags and stage 1
//   bank_*            NUM_BANKS-wide event strobes
//   mem_stall         single memory-side stall strobe
//   crsp_stall        NUM_REQS-wide core response stall strobes
//   perf              master side of the cache perf interface
module vx_perf_cache_counters #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_REQS  = 4,
  parameter int CTR_BITS  = 44,
  parameter bit SATURATE  = 1'b0,
  parameter bit SNAPSHOT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [NUM_BANKS-1:0] bank_rd_fire,
  input  logic [NUM_BANKS-1:0] bank_wr_fire,
  input  logic [NUM_BANKS-1:0] bank_rd_miss,
  input  logic [NUM_BANKS-1:0] bank_wr_miss,
  input  logic [NUM_BANKS-1:0] bank_stall,
  input  logic [NUM_BANKS-1:0] bank_mshr_stall,
  input  logic                 mem_stall,
  input  logic [NUM_REQS-1:0]  crsp_stall,
  vx_perf_cache_counters_if.master perf
);

  localparam int BW = $clog2(NUM_BANKS + 1);
  localparam int RW = $clog2(NUM_REQS + 1);

  typedef logic [CTR_BITS-1:0] ctr_t;

  // Bank event vectors, index k matches counter index k (0..5).
  logic [5:0][NUM_BANKS-1:0] ev_bank;
  logic [5:0][NUM_BANKS-1:0] s1_bank;
  logic                      s1_mem;
  logic [NUM_REQS-1:0]       s1_crsp;

  logic [7:0][CTR_BITS-1:0]  ctr;
  logic [7:0][CTR_BITS-1:0]  inc;
  logic [7:0][CTR_BITS-1:0]  nxt;
  logic [7:0][CTR_BITS-1:0]  out_val;
  logic [7:0]                carry;
  logic [7:0]                ovf;

  assign ev_bank = {bank_mshr_stall, bank_stall, bank_wr_miss,
                    bank_rd_miss, bank_wr_fire, bank_rd_fire};

  function automatic ctr_t pop_bank(input logic [NUM_BANKS-1:0] v);
    logic [BW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_BANKS; i++) n = n + BW'(v[i]);
    return ctr_t'(n);
  endfunction

  function automatic ctr_t pop_req(input logic [NUM_REQS-1:0] v);
    logic [RW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_REQS; i++) n = n + RW'(v[i]);
    return ctr_t'(n);
  endfunction

  // Counter next-state ignoring clear; also what a snapshot captures.
  // The extra MSB of the sum is the carry that raises overflow.
  always_comb begin
    inc   = '0;
    nxt   = '0;
    carry = '0;
    for (int k = 0; k < 6; k++) inc[k] = pop_bank(s1_bank[k]);
    inc[6] = ctr_t'(s1_mem);
    inc[7] = pop_req(s1_crsp);
    for (int k = 0; k < 8; k++) begin
      {carry[k], nxt[k]} = {1'b0, ctr[k]} + {1'b0, inc[k]};
      if (SATURATE && carry[k]) nxt[k] = '1;
    end
  end

  // Clear zeroes stage 1 too, so the increment pending at the clear
  // edge and the clear cycle's own events are both dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_bank <= '0;
      s1_mem  <= 1'b0;
      s1_crsp <= '0;
      ctr     <= '0;
      ovf     <= '0;
    end else if (clear) begin
      s1_bank <= '0;
      s1_mem  <= 1'b0;
      s1_crsp <= '0;
      ctr     <= '0;
      ovf     <= '0;
    end else begin
      s1_bank <= enable ? ev_bank : '0;
      s1_mem  <= enable & mem_stall;
      s1_crsp <= enable ? crsp_stall : '0;
      ctr     <= nxt;
      ovf     <= ovf | carry;
    end
  end

  generate
    if (SNAPSHOT) begin : g_snap
      logic [7:0][CTR_BITS-1:0] shadow;
      logic                     snap_q;

      // Shadows are deliberately untouched by clear so a snapshot taken
      // together with clear still reports the pre-clear totals.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          shadow <= '0;
          snap_q <= 1'b0;
        end else begin
          snap_q <= perf.snap_req;
          if (perf.snap_req) shadow <= nxt;
        end
      end

      assign out_val         = shadow;
      assign perf.snap_valid = snap_q;
    end else begin : g_live
      assign out_val         = ctr;
      assign perf.snap_valid = 1'b0;
    end
  endgenerate

  assign perf.reads        = out_val[0];
  assign perf.writes       = out_val[1];
  assign perf.read_misses  = out_val[2];
  assign perf.write_misses = out_val[3];
  assign perf.bank_stalls  = out_val[4];
  assign perf.mshr_stalls  = out_val[5];
  assign perf.mem_stalls   = out_val[6];
  assign perf.crsp_stalls  = out_val[7];
  assign perf.overflow     = ovf;

endmodule

// File: tb/tb_vx_perf_cache_counters.sv
// Bench for vx_perf_cache_counters. Four instances share one set of
// stimulus: live 44-bit, live 8-bit wrap, live 8-bit saturate and a 44-bit
// snapshot instance. Expected values are queued by the stimulus; a monitor
// on the falling edge retires timed checks and snapshot checks whenever the
// snapshot instance presents snap_valid.
module tb_vx_perf_cache_counters;

  localparam int NB = 4;
  localparam int NR = 4;

  localparam int LIVE = 0, WRAP = 1, SAT = 2, SNAP = 3;
  localparam int RD = 0, WR = 1, RDM = 2, WRM = 3, BST = 4, MST = 5,
                 MEM = 6, CRSP = 7, OVF = 8, SV = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          clear;
  logic [NB-1:0] rd_fire, wr_fire, rd_miss, wr_miss, b_stall, m_stall;
  logic          mem_st;
  logic [NR-1:0] crsp_st;
  logic          snap_req;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          at;
    int          dut;
    int          idx;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  chk_t snq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vx_perf_cache_counters_if #(.CTR_BITS(44)) if_live ();
  vx_perf_cache_counters_if #(.CTR_BITS(8))  if_wrap ();
  vx_perf_cache_counters_if #(.CTR_BITS(8))  if_sat ();
  vx_perf_cache_counters_if #(.CTR_BITS(44)) if_snap ();

  assign if_live.snap_req = snap_req;
  assign if_wrap.snap_req = snap_req;
  assign if_sat.snap_req  = snap_req;
  assign if_snap.snap_req = snap_req;

  vx_perf_cache_counters #(.NUM_BANKS(NB), .NUM_REQS(NR), .CTR_BITS(44),
                           .SATURATE(1'b0), .SNAPSHOT(1'b0)) d_live (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .bank_rd_fire(rd_fire), .bank_wr_fire(wr_fire), .bank_rd_miss(rd_miss),
    .bank_wr_miss(wr_miss), .bank_stall(b_stall), .bank_mshr_stall(m_stall),
    .mem_stall(mem_st), .crsp_stall(crsp_st), .perf(if_live)
  );

  vx_perf_cache_counters #(.NUM_BANKS(NB), .NUM_REQS(NR), .CTR_BITS(8),
                           .SATURATE(1'b0), .SNAPSHOT(1'b0)) d_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .bank_rd_fire(rd_fire), .bank_wr_fire(wr_fire), .bank_rd_miss(rd_miss),
    .bank_wr_miss(wr_miss), .bank_stall(b_stall), .bank_mshr_stall(m_stall),
    .mem_stall(mem_st), .crsp_stall(crsp_st), .perf(if_wrap)
  );

  vx_perf_cache_counters #(.NUM_BANKS(NB), .NUM_REQS(NR), .CTR_BITS(8),
                           .SATURATE(1'b1), .SNAPSHOT(1'b0)) d_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .bank_rd_fire(rd_fire), .bank_wr_fire(wr_fire), .bank_rd_miss(rd_miss),
    .bank_wr_miss(wr_miss), .bank_stall(b_stall), .bank_mshr_stall(m_stall),
    .mem_stall(mem_st), .crsp_stall(crsp_st), .perf(if_sat)
  );

  vx_perf_cache_counters #(.NUM_BANKS(NB), .NUM_REQS(NR), .CTR_BITS(44),
                           .SATURATE(1'b0), .SNAPSHOT(1'b1)) d_snap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .bank_rd_fire(rd_fire), .bank_wr_fire(wr_fire), .bank_rd_miss(rd_miss),
    .bank_wr_miss(wr_miss), .bank_stall(b_stall), .bank_mshr_stall(m_stall),
    .mem_stall(mem_st), .crsp_stall(crsp_st), .perf(if_snap)
  );

  function automatic logic [63:0] pick(input int dut, input int idx);
    logic [9:0][63:0] v;
    case (dut)
      LIVE: v = {64'(if_live.snap_valid), 64'(if_live.overflow), 64'(if_live.crsp_stalls),
                 64'(if_live.mem_stalls), 64'(if_live.mshr_stalls), 64'(if_live.bank_stalls),
                 64'(if_live.write_misses), 64'(if_live.read_misses), 64'(if_live.writes),
                 64'(if_live.reads)};
      WRAP: v = {64'(if_wrap.snap_valid), 64'(if_wrap.overflow), 64'(if_wrap.crsp_stalls),
                 64'(if_wrap.mem_stalls), 64'(if_wrap.mshr_stalls), 64'(if_wrap.bank_stalls),
                 64'(if_wrap.write_misses), 64'(if_wrap.read_misses), 64'(if_wrap.writes),
                 64'(if_wrap.reads)};
      SAT:  v = {64'(if_sat.snap_valid), 64'(if_sat.overflow), 64'(if_sat.crsp_stalls),
                 64'(if_sat.mem_stalls), 64'(if_sat.mshr_stalls), 64'(if_sat.bank_stalls),
                 64'(if_sat.write_misses), 64'(if_sat.read_misses), 64'(if_sat.writes),
                 64'(if_sat.reads)};
      default: v = {64'(if_snap.snap_valid), 64'(if_snap.overflow), 64'(if_snap.crsp_stalls),
                 64'(if_snap.mem_stalls), 64'(if_snap.mshr_stalls), 64'(if_snap.bank_stalls),
                 64'(if_snap.write_misses), 64'(if_snap.read_misses), 64'(if_snap.writes),
                 64'(if_snap.reads)};
    endcase
    return v[idx[3:0]];
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: retire timed checks due this cycle, and pop one snapshot
  // expectation per cycle in which the snapshot instance shows snap_valid.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at == cyc) begin
        compare(sbq[i].name, pick(sbq[i].dut, sbq[i].idx), sbq[i].exp);
        sbq.delete(i);
      end
    end
    if (if_snap.snap_valid === 1'b1) begin
      if (snq.size() == 0) begin
        n_total++;
        $display("[TB] FAIL snap_valid_unexpected: got 1 at cycle %0d, expected 0", cyc);
      end else begin
        chk_t e;
        e = snq.pop_front();
        compare(e.name, pick(SNAP, e.idx), e.exp);
      end
    end
  end

  task automatic check_output(input int at, input int dut, input int idx,
                              input logic [63:0] exp, input string name);
    chk_t e;
    e.at = at; e.dut = dut; e.idx = idx; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic expect_snap(input int idx, input logic [63:0] exp, input string name);
    chk_t e;
    e.at = 0; e.dut = SNAP; e.idx = idx; e.exp = exp; e.name = name;
    snq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one event pattern for n cycles, starting in the current cycle.
  task automatic apply_stimulus(input logic [NB-1:0] rd, input logic [NB-1:0] wr,
                                input logic [NB-1:0] rdm, input logic [NB-1:0] wrm,
                                input logic [NB-1:0] bs, input logic [NB-1:0] ms,
                                input logic mem_v, input logic [NR-1:0] cr, input int n);
    rd_fire = rd; wr_fire = wr; rd_miss = rdm; wr_miss = wrm;
    b_stall = bs; m_stall = ms; mem_st = mem_v; crsp_st = cr;
    tick(n);
  endtask

  task automatic idle(input int n);
    apply_stimulus('0, '0, '0, '0, '0, '0, 1'b0, '0, n);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    reset_n  = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    snap_req = 1'b0;
    idle(1);

    // Reset state
    check_output(cyc, LIVE, RD,  0, "reset_reads");
    check_output(cyc, LIVE, OVF, 0, "reset_overflow");
    check_output(cyc, WRAP, CRSP, 0, "reset_wrap_crsp");
    check_output(cyc, SNAP, WR,  0, "reset_snap_writes");
    check_output(cyc, SNAP, SV,  0, "reset_snap_valid");
    idle(1);
    reset_n = 1'b1;
    enable  = 1'b1;
    idle(1);

    // Single read burst: 3 reads visible exactly two cycles later
    c = cyc;
    check_output(c + 1, LIVE, RD,   0, "lat_reads_early");
    check_output(c + 2, LIVE, RD,   3, "lat_reads");
    check_output(c + 2, LIVE, WR,   0, "lat_writes");
    check_output(c + 2, LIVE, CRSP, 0, "lat_crsp");
    check_output(c + 2, LIVE, OVF,  0, "lat_overflow");
    apply_stimulus(4'b1011, '0, '0, '0, '0, '0, 1'b0, '0, 1);
    idle(3);
    do_clear();

    // Every counter with a distinct popcount in one cycle
    c = cyc;
    check_output(c + 2, LIVE, RD,   4, "mix_reads");
    check_output(c + 2, LIVE, WR,   1, "mix_writes");
    check_output(c + 2, LIVE, RDM,  2, "mix_read_misses");
    check_output(c + 2, LIVE, WRM,  1, "mix_write_misses");
    check_output(c + 2, LIVE, BST,  3, "mix_bank_stalls");
    check_output(c + 2, LIVE, MST,  1, "mix_mshr_stalls");
    check_output(c + 2, LIVE, MEM,  1, "mix_mem_stalls");
    check_output(c + 2, LIVE, CRSP, 2, "mix_crsp_stalls");
    apply_stimulus(4'b1111, 4'b0001, 4'b0011, 4'b0100, 4'b1110, 4'b1000, 1'b1, 4'b0101, 1);
    idle(2);
    do_clear();

    // Enable gating: 5 enabled cycles count, 3 disabled cycles do not
    c = cyc;
    check_output(c + 5, LIVE, CRSP, 16, "en_crsp_inflight");
    check_output(c + 6, LIVE, CRSP, 20, "en_crsp_total");
    check_output(c + 6, LIVE, MEM,   5, "en_mem_total");
    check_output(c + 9, LIVE, CRSP, 20, "en_crsp_hold");
    check_output(c + 9, LIVE, MEM,   5, "en_mem_hold");
    apply_stimulus('0, '0, '0, '0, '0, '0, 1'b1, 4'b1111, 5);
    enable = 1'b0;
    apply_stimulus('0, '0, '0, '0, '0, '0, 1'b1, 4'b1111, 3);
    enable = 1'b1;
    idle(2);
    do_clear();

    // 8-bit wrap vs saturate: preload 254 reads, then +4, then +4 again
    c = cyc;
    check_output(c + 65, WRAP, RD,  254, "wrap_preload");
    check_output(c + 65, WRAP, OVF,   0, "wrap_ovf_before");
    check_output(c + 65, SAT,  RD,  254, "sat_preload");
    check_output(c + 65, SAT,  OVF,   0, "sat_ovf_before");
    check_output(c + 66, WRAP, RD,    2, "wrap_reads");
    check_output(c + 66, WRAP, OVF,   1, "wrap_ovf");
    check_output(c + 66, SAT,  RD,  255, "sat_reads");
    check_output(c + 66, SAT,  OVF,   1, "sat_ovf");
    check_output(c + 67, WRAP, RD,    6, "wrap_reads_again");
    check_output(c + 67, WRAP, OVF,   1, "wrap_ovf_sticky");
    check_output(c + 67, SAT,  RD,  255, "sat_reads_hold");
    check_output(c + 67, SAT,  OVF,   1, "sat_ovf_sticky");
    check_output(c + 67, LIVE, RD,  262, "live_reads_wide");
    check_output(c + 67, LIVE, OVF,   0, "live_no_ovf");
    check_output(c + 69, WRAP, OVF,   0, "wrap_ovf_cleared");
    check_output(c + 69, SAT,  OVF,   0, "sat_ovf_cleared");
    check_output(c + 69, SAT,  RD,    0, "sat_reads_cleared");
    apply_stimulus(4'b1111, '0, '0, '0, '0, '0, 1'b0, '0, 63);
    apply_stimulus(4'b0011, '0, '0, '0, '0, '0, 1'b0, '0, 1);
    apply_stimulus(4'b1111, '0, '0, '0, '0, '0, 1'b0, '0, 2);
    idle(2);
    do_clear();

    // Snapshot including the pending stage-1 increment, then back-to-back
    c = cyc;
    check_output(c + 4, SNAP, WR,  0, "snap_before");
    check_output(c + 5, LIVE, WR, 12, "snap_live_12");
    check_output(c + 5, LIVE, SV,  0, "live_snap_valid_low");
    check_output(c + 6, LIVE, WR, 16, "snap_live_16");
    check_output(c + 6, SNAP, WR, 12, "snap_hold_a");
    check_output(c + 6, SNAP, SV,  0, "snap_valid_one_cycle");
    check_output(c + 7, SNAP, WR, 12, "snap_hold_b");
    check_output(c + 10, SNAP, WR, 21, "snap_final");
    check_output(c + 10, SNAP, SV,  0, "snap_valid_end");
    expect_snap(WR, 12, "snap_writes_12");
    expect_snap(WR, 20, "snap_b2b_first");
    expect_snap(WR, 21, "snap_b2b_second");
    apply_stimulus('0, 4'b1111, '0, '0, '0, '0, 1'b0, '0, 2);
    apply_stimulus('0, 4'b0011, '0, '0, '0, '0, 1'b0, '0, 2);
    snap_req = 1'b1;
    apply_stimulus('0, 4'b1111, '0, '0, '0, '0, 1'b0, '0, 1);
    snap_req = 1'b0;
    apply_stimulus('0, 4'b1111, '0, '0, '0, '0, 1'b0, '0, 1);
    idle(1);
    snap_req = 1'b1;
    apply_stimulus('0, 4'b0001, '0, '0, '0, '0, 1'b0, '0, 1);
    idle(1);
    snap_req = 1'b0;
    idle(2);
    do_clear();

    // Snapshot and clear together: shadow keeps 7+1, counter drops to 0
    c = cyc;
    check_output(c + 3, LIVE, RDM, 7, "sc_live_before");
    check_output(c + 4, LIVE, RDM, 0, "sc_live_cleared");
    check_output(c + 5, LIVE, RDM, 0, "sc_pending_dropped");
    check_output(c + 5, SNAP, RDM, 8, "sc_shadow_hold");
    check_output(c + 4, SNAP, OVF, 0, "sc_overflow");
    check_output(c + 7, SNAP, RDM, 0, "sc_shadow_after");
    expect_snap(RDM, 8, "sc_snap_8");
    expect_snap(RDM, 0, "sc_snap_0");
    apply_stimulus('0, '0, 4'b0111, '0, '0, '0, 1'b0, '0, 1);
    apply_stimulus('0, '0, 4'b1111, '0, '0, '0, 1'b0, '0, 1);
    apply_stimulus('0, '0, 4'b0001, '0, '0, '0, 1'b0, '0, 1);
    snap_req = 1'b1;
    clear    = 1'b1;
    idle(1);
    snap_req = 1'b0;
    clear    = 1'b0;
    idle(1);
    snap_req = 1'b1;
    idle(1);
    snap_req = 1'b0;
    idle(2);

    // Asynchronous reset mid-burst, then counting restarts from zero
    c = cyc;
    check_output(c + 2, LIVE, RD, 4, "rst_before");
    check_output(c + 3, LIVE, RD, 0, "rst_live_now");
    check_output(c + 3, WRAP, RD, 0, "rst_wrap_now");
    check_output(c + 3, SNAP, RD, 0, "rst_shadow_now");
    check_output(c + 4, LIVE, RD, 0, "rst_held");
    check_output(c + 6, LIVE, RD, 0, "rst_resume_early");
    check_output(c + 7, LIVE, RD, 2, "rst_resume");
    check_output(c + 7, WRAP, RD, 2, "rst_resume_wrap");
    check_output(c + 7, LIVE, OVF, 0, "rst_overflow");
    expect_snap(RD, 4, "rst_snap_before");
    apply_stimulus(4'b1111, '0, '0, '0, '0, '0, 1'b0, '0, 1);
    snap_req = 1'b1;
    apply_stimulus(4'b1111, '0, '0, '0, '0, '0, 1'b0, '0, 1);
    snap_req = 1'b0;
    apply_stimulus(4'b1111, '0, '0, '0, '0, '0, 1'b0, '0, 1);
    #1 reset_n = 1'b0;
    idle(1);
    #1 reset_n = 1'b1;
    idle(1);
    apply_stimulus(4'b0011, '0, '0, '0, '0, '0, 1'b0, '0, 1);
    idle(4);

    foreach (sbq[i]) begin
      n_total++;
      $display("[TB] FAIL %s: check for cycle %0d never reached, expected %0d",
               sbq[i].name, sbq[i].at, sbq[i].exp);
    end
    foreach (snq[i]) begin
      n_total++;
      $display("[TB] FAIL %s: snap_valid never presented, expected %0d",
               snq[i].name, snq[i].exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
